// File: rtl/minmax_scanner_pkg.sv
// Shared definitions for the min/max scan engine: state encodings and datapath width.
package minmax_scanner_pkg;

  localparam int MM_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FIRST   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CMP_MAX = 3'd3,
    ST_CMP_MIN = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/comparator_16b.sv
// 16-bit magnitude comparator; negative_sig selects two's-complement ordering.
module comparator_16b
  import minmax_scanner_pkg::*;
(
  input  logic [MM_DATA_W-1:0] a,
  input  logic [MM_DATA_W-1:0] b,
  input  logic                 negative_sig,
  output logic                 great,
  output logic                 less
);

  always_comb begin
    great = 1'b0;
    less  = 1'b0;
    if (negative_sig) begin
      great = $signed(a) > $signed(b);
      less  = $signed(a) < $signed(b);
    end else begin
      great = a > b;
      less  = a < b;
    end
  end

endmodule

// File: rtl/minmax_scanner.sv
// Block min/max scan engine sharing one comparator across the max and min passes.
// Optional occurrence counter for the final maximum is built when MINMAX_MAXCNT_EN is defined.
module minmax_scanner
  import minmax_scanner_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [COUNT_W-1:0]   len,
  input  logic                 signed_mode,
  input  logic                 in_valid,
  input  logic [MM_DATA_W-1:0] in_data,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 done,
  output logic [MM_DATA_W-1:0] max_out,
  output logic [MM_DATA_W-1:0] min_out
`ifdef MINMAX_MAXCNT_EN
  ,
  output logic [COUNT_W-1:0]   max_cnt
`endif
);

  // state      | meaning
  // ST_IDLE    | waiting for start
  // ST_FIRST   | accept first sample, seeds max/min
  // ST_WAIT    | accept next sample into sample_q
  // ST_CMP_MAX | compare sample_q against running max
  // ST_CMP_MIN | compare sample_q against running min, count down
  // ST_DONE    | one-cycle result pulse

  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  state_t                 state_q, state_d;
  logic [COUNT_W-1:0]     len_q;
  logic [COUNT_W-1:0]     remaining_q;
  logic                   mode_q;
  logic [MM_DATA_W-1:0]   sample_q;
  logic [MM_DATA_W-1:0]   max_q;
  logic [MM_DATA_W-1:0]   min_q;
  logic [MM_DATA_W-1:0]   cmp_a;
  logic [MM_DATA_W-1:0]   cmp_b;
  logic                   cmp_great;
  logic                   cmp_less;

  comparator_16b u_cmp (
    .a            (cmp_a),
    .b            (cmp_b),
    .negative_sig (mode_q),
    .great        (cmp_great),
    .less         (cmp_less)
  );

  always_comb begin
    state_d = state_q;
    cmp_a   = '0;
    cmp_b   = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (len != '0) ? ST_FIRST : ST_DONE;
      end
      ST_FIRST: begin
        if (in_valid) state_d = (len_q == ONE) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (in_valid) state_d = ST_CMP_MAX;
      end
      ST_CMP_MAX: begin
        cmp_a   = sample_q;
        cmp_b   = max_q;
        state_d = ST_CMP_MIN;
      end
      ST_CMP_MIN: begin
        cmp_a   = sample_q;
        cmp_b   = min_q;
        state_d = (remaining_q == ONE) ? ST_DONE : ST_WAIT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      remaining_q <= '0;
      mode_q      <= 1'b0;
      sample_q    <= '0;
      max_q       <= '0;
      min_q       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          // Results are held until a new scan is accepted, then cleared.
          if (start) begin
            len_q       <= len;
            mode_q      <= signed_mode;
            remaining_q <= '0;
            max_q       <= '0;
            min_q       <= '0;
          end
        end
        ST_FIRST: begin
          if (in_valid) begin
            max_q       <= in_data;
            min_q       <= in_data;
            remaining_q <= len_q - ONE;
          end
        end
        ST_WAIT: begin
          if (in_valid) sample_q <= in_data;
        end
        ST_CMP_MAX: begin
          if (cmp_great) max_q <= sample_q;
        end
        ST_CMP_MIN: begin
          if (cmp_less) min_q <= sample_q;
          remaining_q <= remaining_q - ONE;
        end
        default: ;
      endcase
    end
  end

`ifdef MINMAX_MAXCNT_EN
  logic [COUNT_W-1:0] max_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) max_cnt_q <= '0;
        ST_FIRST: if (in_valid) max_cnt_q <= ONE;
        ST_CMP_MAX: begin
          // Neither greater nor less means the sample ties the current max.
          if (cmp_great) max_cnt_q <= ONE;
          else if (!cmp_less && max_cnt_q != '1) max_cnt_q <= max_cnt_q + ONE;
        end
        default: ;
      endcase
    end
  end

  assign max_cnt = max_cnt_q;
`endif

  assign in_ready = (state_q == ST_FIRST) || (state_q == ST_WAIT);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign max_out  = max_q;
  assign min_out  = min_q;

endmodule
